// File: rtl/clock_frequency_divider.sv
// rtl/clock_frequency_divider.sv - square-wave clock divider with rising-edge strobe
module clock_frequency_divider #(
    parameter int INPUT_FREQUENCY  = 50000000,
    parameter int OUTPUT_FREQUENCY = 1
) (
    input  logic InClock,
    input  logic reset,
    output logic OutClock,
    output logic OutTick
);

    // Guard the division so a zero output frequency reaches the explicit check below
    // instead of failing as a divide-by-zero during elaboration.
    localparam int HALF_PERIOD   = (OUTPUT_FREQUENCY == 0) ? 0
                                 : INPUT_FREQUENCY / (2 * OUTPUT_FREQUENCY);
    localparam int COUNTER_WIDTH = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int LAST_COUNT    = (HALF_PERIOD > 0) ? HALF_PERIOD - 1 : 0;
    localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(LAST_COUNT);

    // Reject configurations that cannot produce a half period of at least one cycle.
    generate
        if (OUTPUT_FREQUENCY == 0) begin : g_zero_output
            $error("clock_frequency_divider: OUTPUT_FREQUENCY must be non-zero");
        end
        if (OUTPUT_FREQUENCY != 0 && HALF_PERIOD < 1) begin : g_too_fast
            $error("clock_frequency_divider: OUTPUT_FREQUENCY exceeds INPUT_FREQUENCY/2");
        end
    endgenerate

    logic [COUNTER_WIDTH-1:0] counter;

    // Count input cycles, toggle the output clock at each half period and pulse the
    // strobe on the same edge that takes the output clock from 0 to 1.
    always_ff @(posedge InClock) begin
        if (reset) begin
            counter  <= '0;
            OutClock <= 1'b0;
            OutTick  <= 1'b0;
        end else begin
            OutTick <= 1'b0;
            if (counter == LAST) begin
                counter  <= '0;
                OutClock <= ~OutClock;
                OutTick  <= ~OutClock;
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_frequency_divider.sv
// tb/tb_clock_frequency_divider.sv - table-driven, scoreboarded bench for clock_frequency_divider
module tb_clock_frequency_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic a_clk, a_tick, b_clk, b_tick, c_clk, c_tick, d_clk, d_tick;

    // HALF_PERIOD = 5
    clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(10)) dut_a (
        .InClock(clk), .reset(rst), .OutClock(a_clk), .OutTick(a_tick));
    // HALF_PERIOD = 1
    clock_frequency_divider #(.INPUT_FREQUENCY(4), .OUTPUT_FREQUENCY(2)) dut_b (
        .InClock(clk), .reset(rst), .OutClock(b_clk), .OutTick(b_tick));
    // HALF_PERIOD = floor(105/20) = 5
    clock_frequency_divider #(.INPUT_FREQUENCY(105), .OUTPUT_FREQUENCY(10)) dut_c (
        .InClock(clk), .reset(rst), .OutClock(c_clk), .OutTick(c_tick));
    // HALF_PERIOD = 2500000
    clock_frequency_divider #(.OUTPUT_FREQUENCY(10)) dut_d (
        .InClock(clk), .reset(rst), .OutClock(d_clk), .OutTick(d_tick));

    typedef struct {
        logic rst;
        int   k;      // edges since last reset release, after this edge
    } vec_t;

    typedef struct {
        logic a_clk, a_tick, b_clk, b_tick, c_clk, c_tick, d_clk, d_tick;
        int   a_cnt;
    } exp_t;

    typedef struct {
        logic rst;
        int   len;
    } seg_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic exp_clk(int k, int h);
        return ((k / h) % 2) == 1;
    endfunction

    function automatic logic exp_tick(int k, int h);
        return (k % (2 * h)) == h;
    endfunction

    task automatic check(string name, int idx, int act, int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, req);
        end
    endtask

    initial begin
        seg_t segs[6];
        int   k;
        exp_t e;
        int   cyc;
        int   highs, a_ticks, b_ticks, d_highs;
        logic found;

        // Reset 3 cycles, run into a high level, reset one edge at edge 7, then run on.
        segs[0] = '{1'b1, 3};
        segs[1] = '{1'b0, 6};
        segs[2] = '{1'b1, 1};
        segs[3] = '{1'b0, 22};
        segs[4] = '{1'b1, 2};
        segs[5] = '{1'b0, 12};
        k = 0;
        foreach (segs[s]) begin
            for (int i = 0; i < segs[s].len; i++) begin
                if (segs[s].rst) k = 0;
                else k++;
                vecs.push_back('{segs[s].rst, k});
            end
        end

        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            e.a_clk  = exp_clk(vecs[i].k, 5);
            e.a_tick = exp_tick(vecs[i].k, 5);
            e.b_clk  = exp_clk(vecs[i].k, 1);
            e.b_tick = exp_tick(vecs[i].k, 1);
            e.c_clk  = exp_clk(vecs[i].k, 5);
            e.c_tick = exp_tick(vecs[i].k, 5);
            e.d_clk  = exp_clk(vecs[i].k, 2500000);
            e.d_tick = exp_tick(vecs[i].k, 2500000);
            e.a_cnt  = vecs[i].k % 5;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("a_clk",  i, int'(a_clk),  int'(e.a_clk));
            check("a_tick", i, int'(a_tick), int'(e.a_tick));
            check("a_cnt",  i, int'(dut_a.counter), e.a_cnt);
            check("b_clk",  i, int'(b_clk),  int'(e.b_clk));
            check("b_tick", i, int'(b_tick), int'(e.b_tick));
            check("c_clk",  i, int'(c_clk),  int'(e.c_clk));
            check("c_tick", i, int'(c_tick), int'(e.c_tick));
            check("d_clk",  i, int'(d_clk),  int'(e.d_clk));
            check("d_tick", i, int'(d_tick), int'(e.d_tick));
        end

        // Reset again and measure latency to the first strobe with a bounded wait.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (a_tick) begin
                found = 1'b1;
                break;
            end
        end
        check("first_tick_seen", 0, int'(found), 1);
        check("first_tick_latency", 0, cyc, 5);
        check("first_tick_clk_high", 0, int'(a_clk), 1);

        // Duty cycle and strobe rate over ten full periods.
        highs = 0; a_ticks = 0; b_ticks = 0; d_highs = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (a_clk) highs++;
            if (a_tick) begin
                a_ticks++;
                check("tick_on_rise", i, int'(a_clk), 1);
            end
            if (b_tick) b_ticks++;
            if (d_clk || d_tick) d_highs++;
        end
        check("a_duty_high_cycles", 0, highs, 50);
        check("a_ticks_per_100", 0, a_ticks, 10);
        check("b_ticks_per_100", 0, b_ticks, 50);
        check("d_quiet", 0, d_highs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
